// File: rtl/xor_stage_seq.sv
// -----------------------------------------------------------------------------
// xor_stage_seq
//
// XOR injection stage that sits next to an ASCON permutation. Each accepted
// operation applies the key, data or domain-separation XOR that belongs to the
// current phase of an ASCON-128 / ASCON-128a run. The result lands in a single
// output register with a valid/ready handshake (1-cycle latency, full
// throughput). A small phase FSM tracks the legal sequence
// INIT_END -> AD_ABS* -> DOM_SEP -> PT_ABS* -> FIN_BEGIN -> TAG.
// An out-of-sequence operation is still accepted, but it is treated as a
// pass-through and raises a sticky error flag.
//
// State word layout on state_i/state_o: x0 = [63:0], x1 = [127:64], ...,
// x4 = [319:256]. In other words the vector is {x4, x3, x2, x1, x0}.
//
// Parameters
//   RATE_WORDS  1 = ASCON-128 (64-bit rate), 2 = ASCON-128a (128-bit rate)
//
// Ports
//   clock_i    in   1              clock, rising edge
//   resetb_i   in   1              asynchronous active-low reset
//   clear_i    in   1              synchronous flush (FSM, output reg, err, count)
//   valid_i    in   1              operation present
//   ready_o    out  1              operation can be accepted this cycle
//   op_i       in   3              0 PASS, 1 INIT_END, 2 AD_ABS, 3 DOM_SEP,
//                                  4 PT_ABS, 5 FIN_BEGIN, 6 TAG, 7 illegal
//   data_i     in   64*RATE_WORDS  data block for AD_ABS / PT_ABS
//   key_i      in   128            secret key
//   state_i    in   320            state from the permutation
//   valid_o    out  1              output register holds a result
//   ready_i    in   1              downstream takes the result
//   state_o    out  320            registered result state
//   cipher_o   out  64*RATE_WORDS  registered ciphertext (after PT_ABS)
//   tag_o      out  128            registered tag (after TAG)
//   err_o      out  1              sticky illegal-sequence flag
//   blk_cnt_o  out  8              saturating count of legal AD/PT blocks
// -----------------------------------------------------------------------------
module xor_stage_seq #(
    parameter int RATE_WORDS = 1
) (
    input  logic                       clock_i,
    input  logic                       resetb_i,
    input  logic                       clear_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [2:0]                 op_i,
    input  logic [64*RATE_WORDS-1:0]   data_i,
    input  logic [127:0]               key_i,
    input  logic [319:0]               state_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [319:0]               state_o,
    output logic [64*RATE_WORDS-1:0]   cipher_o,
    output logic [127:0]               tag_o,
    output logic                       err_o,
    output logic [7:0]                 blk_cnt_o
);

    localparam int RATE_W = 64 * RATE_WORDS;

    // Operation encodings
    localparam logic [2:0] OP_PASS      = 3'd0;
    localparam logic [2:0] OP_INIT_END  = 3'd1;
    localparam logic [2:0] OP_AD_ABS    = 3'd2;
    localparam logic [2:0] OP_DOM_SEP   = 3'd3;
    localparam logic [2:0] OP_PT_ABS    = 3'd4;
    localparam logic [2:0] OP_FIN_BEGIN = 3'd5;
    localparam logic [2:0] OP_TAG       = 3'd6;

    // Phase FSM encodings
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_AD   = 3'd2;
    localparam logic [2:0] S_PT   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    // Only the two ASCON rates exist; anything else is a configuration error.
    generate
        if (RATE_WORDS != 1 && RATE_WORDS != 2) begin : g_bad_rate
            $error("xor_stage_seq: RATE_WORDS must be 1 or 2");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [2:0]          fsm_q,     fsm_d;
    logic                valid_q,   valid_d;
    logic [319:0]        state_q,   state_d;
    logic [RATE_W-1:0]   cipher_q,  cipher_d;
    logic [127:0]        tag_q,     tag_d;
    logic                err_q,     err_d;
    logic [7:0]          blk_cnt_q, blk_cnt_d;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic accept;

    // The output register can take a new result when it is empty or being
    // drained this same cycle; a flush blocks acceptance outright.
    assign ready_o = !clear_i && (!valid_q || ready_i);
    assign accept  = valid_i && ready_o;

    // -------------------------------------------------------------------------
    // Sequence legality and phase transition
    // -------------------------------------------------------------------------
    logic       op_legal;
    logic [2:0] fsm_target;

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the case statements can infer a latch.
    always_comb begin
        op_legal   = 1'b0;
        fsm_target = fsm_q;
        case (op_i)
            OP_PASS: begin
                op_legal = 1'b1;
            end
            OP_INIT_END: begin
                if (fsm_q == S_IDLE) begin
                    op_legal   = 1'b1;
                    fsm_target = S_INIT;
                end
            end
            OP_AD_ABS: begin
                if (fsm_q == S_INIT || fsm_q == S_AD) begin
                    op_legal   = 1'b1;
                    fsm_target = S_AD;
                end
            end
            OP_DOM_SEP: begin
                // AD is optional: DOM_SEP may follow INIT_END directly.
                if (fsm_q == S_INIT || fsm_q == S_AD) begin
                    op_legal   = 1'b1;
                    fsm_target = S_PT;
                end
            end
            OP_PT_ABS: begin
                if (fsm_q == S_PT) begin
                    op_legal = 1'b1;
                end
            end
            OP_FIN_BEGIN: begin
                if (fsm_q == S_PT) begin
                    op_legal   = 1'b1;
                    fsm_target = S_FIN;
                end
            end
            OP_TAG: begin
                if (fsm_q == S_FIN) begin
                    op_legal   = 1'b1;
                    fsm_target = S_IDLE;
                end
            end
            default: begin
                // op 7 is never legal
                op_legal = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // XOR datapath
    // -------------------------------------------------------------------------
    logic [4:0][63:0] x_in;
    logic [4:0][63:0] x_res;
    logic [63:0]      data_lo;
    logic [63:0]      data_hi;
    logic [63:0]      key_hi;
    logic [63:0]      key_lo;
    logic [RATE_W-1:0] rate_res;

    assign x_in    = state_i;
    assign data_lo = data_i[63:0];
    assign key_hi  = key_i[127:64];
    assign key_lo  = key_i[63:0];

    // Second rate word only exists for ASCON-128a; with a 64-bit rate the
    // x1 absorb term is zero and the ciphertext is just x0.
    generate
        if (RATE_WORDS == 2) begin : g_rate2
            assign data_hi  = data_i[RATE_W-1:64];
            assign rate_res = {x_res[1], x_res[0]};
        end else begin : g_rate1
            assign data_hi  = 64'h0;
            assign rate_res = x_res[0];
        end
    endgenerate

    // NOTE: combinational logic uses blocking assignments so later lines see
    // the updated x_res; clocked state below uses non-blocking assignments.
    always_comb begin
        x_res = x_in;
        // Illegal ops degrade to PASS, so the XOR only applies when legal.
        if (op_legal) begin
            case (op_i)
                OP_INIT_END: begin
                    x_res[3] = x_in[3] ^ key_hi;
                    x_res[4] = x_in[4] ^ key_lo;
                end
                OP_AD_ABS, OP_PT_ABS: begin
                    x_res[0] = x_in[0] ^ data_lo;
                    x_res[1] = x_in[1] ^ data_hi;
                end
                OP_DOM_SEP: begin
                    x_res[4] = x_in[4] ^ 64'h1;
                end
                OP_FIN_BEGIN: begin
                    // The key sits right after the rate, so its position
                    // moves up one word for the 128-bit rate variant.
                    if (RATE_WORDS == 1) begin
                        x_res[1] = x_in[1] ^ key_hi;
                        x_res[2] = x_in[2] ^ key_lo;
                    end else begin
                        x_res[2] = x_in[2] ^ key_hi;
                        x_res[3] = x_in[3] ^ key_lo;
                    end
                end
                default: begin
                    x_res = x_in;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Next-state selection: flush beats acceptance beats drain.
    // -------------------------------------------------------------------------
    always_comb begin
        fsm_d     = fsm_q;
        valid_d   = valid_q;
        state_d   = state_q;
        cipher_d  = cipher_q;
        tag_d     = tag_q;
        err_d     = err_q;
        blk_cnt_d = blk_cnt_q;

        if (clear_i) begin
            fsm_d     = S_IDLE;
            valid_d   = 1'b0;
            state_d   = '0;
            cipher_d  = '0;
            tag_d     = '0;
            err_d     = 1'b0;
            blk_cnt_d = 8'd0;
        end else if (accept) begin
            fsm_d    = fsm_target;
            valid_d  = 1'b1;
            state_d  = x_res;
            // cipher_o and tag_o are reloaded on every acceptance; they only
            // carry meaning after PT_ABS and TAG respectively.
            cipher_d = rate_res;
            tag_d    = {x_res[3], x_res[4]} ^ key_i;
            if (!op_legal) begin
                err_d = 1'b1;
            end else if (op_i == OP_INIT_END) begin
                blk_cnt_d = 8'd0;
            end else if ((op_i == OP_AD_ABS || op_i == OP_PT_ABS) &&
                         blk_cnt_q != 8'hFF) begin
                blk_cnt_d = blk_cnt_q + 8'd1;
            end
        end else if (ready_i) begin
            // Handshake with nothing new behind it empties the register;
            // the data words are left as-is since valid_o qualifies them.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q     <= S_IDLE;
            valid_q   <= 1'b0;
            state_q   <= '0;
            cipher_q  <= '0;
            tag_q     <= '0;
            err_q     <= 1'b0;
            blk_cnt_q <= 8'd0;
        end else begin
            fsm_q     <= fsm_d;
            valid_q   <= valid_d;
            state_q   <= state_d;
            cipher_q  <= cipher_d;
            tag_q     <= tag_d;
            err_q     <= err_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign valid_o   = valid_q;
    assign state_o   = state_q;
    assign cipher_o  = cipher_q;
    assign tag_o     = tag_q;
    assign err_o     = err_q;
    assign blk_cnt_o = blk_cnt_q;

endmodule

// File: tb/tb_xor_stage_seq.sv
// -----------------------------------------------------------------------------
// tb_xor_stage_seq
//
// Directed bench for xor_stage_seq. Two instances share the control inputs:
// dut1 uses a 64-bit rate, dut2 a 128-bit rate. Expected values are written
// out by hand from the XOR rules. Inputs change 1 ns after the rising edge,
// and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_xor_stage_seq;

    localparam logic [2:0] OP_PASS      = 3'd0;
    localparam logic [2:0] OP_INIT_END  = 3'd1;
    localparam logic [2:0] OP_AD_ABS    = 3'd2;
    localparam logic [2:0] OP_DOM_SEP   = 3'd3;
    localparam logic [2:0] OP_PT_ABS    = 3'd4;
    localparam logic [2:0] OP_FIN_BEGIN = 3'd5;
    localparam logic [2:0] OP_TAG       = 3'd6;
    localparam logic [2:0] OP_ILLEGAL   = 3'd7;

    localparam logic [127:0] KEY  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [63:0]  KHI  = 64'h0001020304050607;
    localparam logic [63:0]  KLO  = 64'h08090A0B0C0D0E0F;
    localparam logic [63:0]  ONES = 64'hFFFFFFFFFFFFFFFF;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic         valid_in;
    logic [2:0]   op;
    logic [127:0] data;
    logic [127:0] key;
    logic [319:0] state_in;
    logic         ready_in;

    logic         r1_ready, r1_valid, r1_err;
    logic [319:0] r1_state;
    logic [63:0]  r1_cipher;
    logic [127:0] r1_tag;
    logic [7:0]   r1_cnt;

    logic         r2_ready, r2_valid, r2_err;
    logic [319:0] r2_state;
    logic [127:0] r2_cipher;
    logic [127:0] r2_tag;
    logic [7:0]   r2_cnt;

    int n_pass;
    int n_fail;
    int n_total;

    xor_stage_seq #(.RATE_WORDS(1)) dut1 (
        .clock_i   (clk),
        .resetb_i  (rst_n),
        .clear_i   (clear),
        .valid_i   (valid_in),
        .ready_o   (r1_ready),
        .op_i      (op),
        .data_i    (data[63:0]),
        .key_i     (key),
        .state_i   (state_in),
        .valid_o   (r1_valid),
        .ready_i   (ready_in),
        .state_o   (r1_state),
        .cipher_o  (r1_cipher),
        .tag_o     (r1_tag),
        .err_o     (r1_err),
        .blk_cnt_o (r1_cnt)
    );

    xor_stage_seq #(.RATE_WORDS(2)) dut2 (
        .clock_i   (clk),
        .resetb_i  (rst_n),
        .clear_i   (clear),
        .valid_i   (valid_in),
        .ready_o   (r2_ready),
        .op_i      (op),
        .data_i    (data),
        .key_i     (key),
        .state_i   (state_in),
        .valid_o   (r2_valid),
        .ready_i   (ready_in),
        .state_o   (r2_state),
        .cipher_o  (r2_cipher),
        .tag_o     (r2_tag),
        .err_o     (r2_err),
        .blk_cnt_o (r2_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [319:0] pack(input logic [63:0] x0, input logic [63:0] x1,
                                          input logic [63:0] x2, input logic [63:0] x3,
                                          input logic [63:0] x4);
        return {x4, x3, x2, x1, x0};
    endfunction

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operation for exactly one edge, then sample 1 ns later.
    task automatic issue(input logic [2:0] o, input logic [127:0] d, input logic [319:0] s);
        op       = o;
        data     = d;
        state_in = s;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    logic [319:0] p1, p2, p3;

    initial begin
        n_pass   = 0;
        n_fail   = 0;
        n_total  = 0;
        rst_n    = 1'b0;
        clear    = 1'b0;
        valid_in = 1'b0;
        op       = OP_PASS;
        data     = '0;
        key      = KEY;
        state_in = '0;
        ready_in = 1'b1;
        p1 = pack(64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
                  64'h4444444444444444, 64'h5555555555555555);
        p2 = pack(64'hA5A5A5A5A5A5A5A5, 64'h0, 64'hDEADBEEFDEADBEEF, 64'h0, 64'h7);
        p3 = pack(64'h0, 64'hCAFEF00DCAFEF00D, 64'h0, 64'h123, 64'h0);

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_valid",  320'(r1_valid),  320'(0));
        check("rst_state",  r1_state,        320'(0));
        check("rst_cipher", 320'(r1_cipher), 320'(0));
        check("rst_tag",    320'(r1_tag),    320'(0));
        check("rst_err",    320'(r1_err),    320'(0));
        check("rst_cnt",    320'(r1_cnt),    320'(0));
        rst_n = 1'b1;
        #1;
        check("rst_ready_after", 320'(r1_ready), 320'(1));

        // ---------------- full ASCON-128 sequence ----------------
        issue(OP_INIT_END, '0, pack(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0,
                                   ONES, 64'h5555555555555555));
        check("init_valid", 320'(r1_valid), 320'(1));
        check("init_state", r1_state, pack(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0,
                                          64'hFFFEFDFCFBFAF9F8, 64'h5D5C5F5E59585B5A));
        check("init_cnt", 320'(r1_cnt), 320'(0));

        issue(OP_AD_ABS, 128'hAAAAAAAAAAAAAAAA, pack(64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                                     64'h0, 64'h0, 64'h0));
        check("ad1_state", r1_state, pack(64'hAB89EFCD23016745, 64'hFEDCBA9876543210,
                                         64'h0, 64'h0, 64'h0));
        check("ad1_cnt", 320'(r1_cnt), 320'(1));

        issue(OP_AD_ABS, {64'h0, ONES}, '0);
        check("ad2_state", r1_state, pack(ONES, 64'h0, 64'h0, 64'h0, 64'h0));
        check("ad2_cnt", 320'(r1_cnt), 320'(2));

        issue(OP_DOM_SEP, '0, '0);
        check("dom_state", r1_state, pack(64'h0, 64'h0, 64'h0, 64'h0, 64'h1));

        issue(OP_PT_ABS, 128'h0F0F0F0F0F0F0F0F, pack(64'hFF00FF00FF00FF00, 64'h0, 64'h0,
                                                     64'h0, 64'h0));
        check("pt_state",  r1_state, pack(64'hF00FF00FF00FF00F, 64'h0, 64'h0, 64'h0, 64'h0));
        check("pt_cipher", 320'(r1_cipher), 320'(64'hF00FF00FF00FF00F));
        check("pt_cnt",    320'(r1_cnt), 320'(3));

        issue(OP_FIN_BEGIN, '0, '0);
        check("fin_state", r1_state, pack(64'h0, KHI, KLO, 64'h0, 64'h0));

        issue(OP_TAG, '0, pack(64'h0, 64'h0, 64'h0, 64'h0001020304050607, 64'h1));
        check("tag_state", r1_state, pack(64'h0, 64'h0, 64'h0, 64'h0001020304050607, 64'h1));
        check("tag_value", 320'(r1_tag), 320'(128'h0000000000000000_08090A0B0C0D0E0E));
        check("tag_cnt",   320'(r1_cnt), 320'(3));
        check("tag_err",   320'(r1_err), 320'(0));

        // Back in S_IDLE, so INIT_END is legal and restarts the count.
        issue(OP_INIT_END, '0, '0);
        check("reinit_err", 320'(r1_err), 320'(0));
        check("reinit_cnt", 320'(r1_cnt), 320'(0));

        // ---------------- backpressure ----------------
        tick();
        check("drain_valid", 320'(r1_valid), 320'(0));
        ready_in = 1'b0;
        issue(OP_PASS, '0, p1);
        check("bp_first", r1_state, p1);
        state_in = p2;
        op       = OP_PASS;
        valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready_low", 320'(r1_ready), 320'(0));
            check("bp_hold",      r1_state, p1);
            tick();
        end
        check("bp_valid_held", 320'(r1_valid), 320'(1));
        ready_in = 1'b1;
        #1;
        check("bp_ready_high", 320'(r1_ready), 320'(1));
        tick();
        check("bp_next", r1_state, p2);
        state_in = p3;
        tick();
        check("bp_b2b_valid", 320'(r1_valid), 320'(1));
        check("bp_b2b_state", r1_state, p3);
        valid_in = 1'b0;
        tick();
        check("bp_drain", 320'(r1_valid), 320'(0));

        // ---------------- clear priority ----------------
        ready_in = 1'b0;
        issue(OP_PASS, '0, p1);
        clear    = 1'b1;
        valid_in = 1'b1;
        op       = OP_AD_ABS;
        #1;
        check("clr_ready", 320'(r1_ready), 320'(0));
        tick();
        clear    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        check("clr_valid", 320'(r1_valid), 320'(0));
        check("clr_cnt",   320'(r1_cnt),   320'(0));

        // ---------------- illegal PT_ABS from S_IDLE ----------------
        #1;
        check("ill_err_before", 320'(r1_err), 320'(0));
        issue(OP_PT_ABS, {64'h0, ONES}, p1);
        check("ill_state", r1_state, p1);
        check("ill_err",   320'(r1_err), 320'(1));
        check("ill_cnt",   320'(r1_cnt), 320'(0));
        // FSM must still be S_IDLE: INIT_END then AD_ABS are both legal.
        issue(OP_INIT_END, '0, '0);
        issue(OP_AD_ABS, '0, '0);
        check("ill_fsm_idle", 320'(r1_cnt), 320'(1));
        check("ill_err_sticky", 320'(r1_err), 320'(1));
        flush();
        check("ill_clear_err", 320'(r1_err), 320'(0));
        check("ill_clear_cnt", 320'(r1_cnt), 320'(0));

        // ---------------- counter saturation ----------------
        issue(OP_INIT_END, '0, '0);
        op       = OP_AD_ABS;
        data     = '0;
        state_in = '0;
        valid_in = 1'b1;
        repeat (254) @(posedge clk);
        #1;
        check("sat_254", 320'(r1_cnt), 320'(254));
        repeat (46) @(posedge clk);
        #1;
        valid_in = 1'b0;
        check("sat_255", 320'(r1_cnt), 320'(255));
        check("sat_err", 320'(r1_err), 320'(0));
        issue(OP_INIT_END, '0, p2);
        check("sat_init_err",   320'(r1_err), 320'(1));
        check("sat_init_cnt",   320'(r1_cnt), 320'(255));
        check("sat_init_state", r1_state, p2);

        // ---------------- ASCON-128a rate ----------------
        flush();
        issue(OP_INIT_END, '0, '0);
        check("a_init_state", r2_state, pack(64'h0, 64'h0, 64'h0, KHI, KLO));
        issue(OP_DOM_SEP, '0, '0);
        issue(OP_PT_ABS, {ONES, ONES}, '0);
        check("a_pt_state",  r2_state, pack(ONES, ONES, 64'h0, 64'h0, 64'h0));
        check("a_pt_cipher", 320'(r2_cipher), 320'({ONES, ONES}));
        check("a_pt_cipher64", 320'(r1_cipher), 320'(ONES));
        issue(OP_FIN_BEGIN, '0, '0);
        check("a_fin_state", r2_state, pack(64'h0, 64'h0, KHI, KLO, 64'h0));
        check("a_fin_state64", r1_state, pack(64'h0, KHI, KLO, 64'h0, 64'h0));
        check("a_cnt", 320'(r2_cnt), 320'(1));
        check("a_err", 320'(r2_err), 320'(0));
        issue(OP_ILLEGAL, '0, p1);
        check("op7_state", r1_state, p1);
        check("op7_err",   320'(r1_err), 320'(1));

        // ---------------- reset while holding a result ----------------
        issue(OP_PASS, '0, p3);
        ready_in = 1'b0;
        tick();
        check("hold_valid", 320'(r1_valid), 320'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",  320'(r1_valid),  320'(0));
        check("mid_rst_state",  r1_state,        320'(0));
        check("mid_rst_cipher", 320'(r1_cipher), 320'(0));
        check("mid_rst_tag",    320'(r1_tag),    320'(0));
        check("mid_rst_err",    320'(r1_err),    320'(0));
        check("mid_rst_cnt",    320'(r1_cnt),    320'(0));
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 320'(r1_ready), 320'(1));
        tick();
        check("post_rst_valid", 320'(r1_valid), 320'(0));
        ready_in = 1'b1;
        issue(OP_INIT_END, '0, '0);
        check("post_rst_idle", 320'(r1_err), 320'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/xor_stage_seq.md
XOR_STAGE_SEQ -- requirements
Module: xor_stage_seq

Interface
REQ-001 Parameter RATE_WORDS, default 1: rate words per block; 1 = ASCON-128 (64-bit rate), 2 = ASCON-128a (128-bit rate); other values SHALL be rejected at elaboration.
REQ-002 clock_i  in  1  single clock; all state updates on rising edge.
REQ-003 resetb_i  in  1  asynchronous active-low reset.
REQ-004 clear_i  in  1  synchronous flush: FSM to S_IDLE, output register empty, err_o and blk_cnt_o cleared.
REQ-005 valid_i  in  1  input operation present.
REQ-006 ready_o  out  1  block can accept an operation this cycle.
REQ-007 op_i  in  3  operation: 0 PASS, 1 INIT_END, 2 AD_ABS, 3 DOM_SEP, 4 PT_ABS, 5 FIN_BEGIN, 6 TAG; 7 illegal.
REQ-008 data_i  in  64*RATE_WORDS  data block for AD_ABS and PT_ABS.
REQ-009 key_i  in  128  secret key.
REQ-010 state_i  in  type_state  5x64 ASCON state from the permutation.
REQ-011 valid_o  out  1  output register holds a result.
REQ-012 ready_i  in  1  downstream accepts the result.
REQ-013 state_o  out  type_state  registered result state.
REQ-014 cipher_o  out  64*RATE_WORDS  registered ciphertext; meaningful only after PT_ABS.
REQ-015 tag_o  out  128  registered tag; meaningful only after TAG.
REQ-016 err_o  out  1  sticky illegal-sequence flag.
REQ-017 blk_cnt_o  out  8  count of accepted AD_ABS plus PT_ABS operations.

Function
REQ-018 Acceptance SHALL occur when valid_i=1 and ready_o=1; ready_o = !clear_i and (!valid_o or ready_i).
REQ-019 Latency SHALL be exactly 1 cycle: result is registered at the acceptance edge, and valid_o rises the next cycle.
REQ-020 The output register SHALL hold state_o/cipher_o/tag_o stable while valid_o=1 and ready_i=0; valid_o falls after a handshake with no new acceptance.
REQ-021 Simultaneous drain and accept (valid_o=1, ready_i=1, valid_i=1) SHALL load the new result with valid_o staying 1 (full throughput).
REQ-022 PASS: state_o = state_i, in any FSM state, with no FSM change.
REQ-023 INIT_END: x3,x4 ^= key_i (key_i[127:64] into x3).
REQ-024 AD_ABS: x0 ^= data_i[63:0]; with RATE_WORDS=2, also x1 ^= data_i[127:64].
REQ-025 DOM_SEP: x4[0] ^= 1; all other bits unchanged.
REQ-026 PT_ABS: rate words XORed as in AD_ABS; cipher_o = resulting rate words.
REQ-027 FIN_BEGIN: RATE_WORDS=1 -> x1,x2 ^= key_i; RATE_WORDS=2 -> x2,x3 ^= key_i (high key half into lower-index word).
REQ-028 TAG: state_o = state_i; tag_o = {x3,x4} ^ key_i.
REQ-029 The FSM SHALL have states S_IDLE, S_INIT, S_AD, S_PT, S_FIN with these legal transitions:
- S_IDLE: INIT_END -> S_INIT
- S_INIT: AD_ABS -> S_AD; DOM_SEP -> S_PT
- S_AD: AD_ABS -> stay; DOM_SEP -> S_PT
- S_PT: PT_ABS -> stay; FIN_BEGIN -> S_FIN
- S_FIN: TAG -> S_IDLE
REQ-030 An illegal op for the current FSM state, including op 7, SHALL be accepted, behave as PASS, leave the FSM unchanged, and set err_o.
REQ-031 err_o SHALL stay set until reset or clear_i.
REQ-032 blk_cnt_o SHALL increment on each legal AD_ABS or PT_ABS acceptance, saturate at 255, and reset to 0 on INIT_END acceptance.
REQ-033 clear_i SHALL take priority over acceptance and over output handshake; the pending output is discarded.
REQ-034 The FSM, err_o and blk_cnt_o SHALL update only on acceptance or clear_i, never on output handshake.

Reset
REQ-035 While resetb_i=0, outputs SHALL be: valid_o=0, state_o=0, cipher_o=0, tag_o=0, err_o=0, blk_cnt_o=0, FSM=S_IDLE.
REQ-036 Reset asserted mid-operation SHALL discard any held result, with no glitch on valid_o after release.
REQ-037 ready_o SHALL be 1 on the first cycle after reset release.

Verification
REQ-038 Full sequence with RATE_WORDS=1 and key=0x000102..0F: INIT_END, two AD_ABS, DOM_SEP, one PT_ABS, FIN_BEGIN, TAG -> each output matches the XOR rules; blk_cnt_o=3; FSM back in S_IDLE; err_o=0.
REQ-039 RATE_WORDS=2 with data_i=0xFFFF..FF and state_i all zero -> PT_ABS gives x0=x1=cipher_o=all ones; FIN_BEGIN puts the key into x2,x3.
REQ-040 Backpressure: hold ready_i=0 for 5 cycles -> state_o stable and ready_o=0; then ready_i=1 with valid_i=1 -> back-to-back results, no bubble.
REQ-041 PT_ABS issued from S_IDLE -> output equals state_i, err_o=1 from the next cycle, FSM stays S_IDLE; then clear_i -> err_o=0.
REQ-042 300 consecutive AD_ABS ops -> blk_cnt_o saturates at 255; a following INIT_END is illegal in S_AD, so err_o=1 and the count is unchanged.
REQ-043 Reset asserted while valid_o=1 and ready_i=0 -> all outputs 0 immediately; after release, ready_o=1 and the FSM is S_IDLE.
